// File: rtl/pipeline_types.sv
// Shared pipeline record types for the front end and the branch resolution path.
// Holds the resolution-side update record plus the predictor's own types and width helpers.
package pipeline_types;

    typedef struct packed {
        logic        update_en;
        logic        taken_or_not_actual;
        logic        branch_flush;
        logic [31:0] branch_actual_addr;
        logic [31:0] pc_dispatch;
    } branch_update;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
    } bpu_pred_t;

    typedef enum logic [1:0] {
        BPU_CNT_SNT = 2'b00,
        BPU_CNT_WNT = 2'b01,
        BPU_CNT_WT  = 2'b10,
        BPU_CNT_ST  = 2'b11
    } bpu_cnt_e;

    // Word-aligned PCs: index starts at bit 2, tag is everything above the index.
    function automatic int bpu_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int bpu_tag_w(input int depth);
        return 30 - $clog2(depth);
    endfunction

endpackage

// File: rtl/branch_predictor_table_btb_ram.sv
// Direct-mapped branch target buffer: valid/tag/target per entry, one async read port
// and one write port. Only the valid bits are reset.
module btb_ram
    import pipeline_types::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = bpu_idx_w(DEPTH),
    parameter int TAG_W = bpu_tag_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    // Reads return the state before any same-cycle write.
    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/branch_predictor_table.sv
// Front-end branch predictor: 2-bit saturating BHT plus tagged BTB, trained by resolved
// branch updates, answering one fetch-PC query per cycle with a registered prediction.
module branch_predictor_table
    import pipeline_types::*;
#(
    parameter int BHT_DEPTH = 256,
    parameter int BTB_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fetch_valid,
    input  logic         fetch_stall,
    input  logic [31:0]  fetch_pc,
    input  branch_update update_info,
    output logic         pred_valid,
    output logic         pre_is_branch_taken,
    output logic [31:0]  pre_branch_addr,
    output logic [31:0]  pred_pc
);

    localparam int BHT_IDX_W = bpu_idx_w(BHT_DEPTH);
    localparam int BTB_IDX_W = bpu_idx_w(BTB_DEPTH);
    localparam int BTB_TAG_W = bpu_tag_w(BTB_DEPTH);

    logic [BHT_IDX_W-1:0] q_bht_idx;
    logic [BTB_IDX_W-1:0] q_btb_idx;
    logic [BTB_TAG_W-1:0] q_tag;
    logic [BHT_IDX_W-1:0] u_bht_idx;
    logic [BTB_IDX_W-1:0] u_btb_idx;
    logic [BTB_TAG_W-1:0] u_tag;

    logic                 btb_rd_valid;
    logic [BTB_TAG_W-1:0] btb_rd_tag;
    logic [31:0]          btb_rd_target;
    logic                 btb_hit;
    logic                 q_taken;
    logic                 btb_wr_en;

    bpu_cnt_e  cnt_q [BHT_DEPTH];
    bpu_cnt_e  cnt_d [BHT_DEPTH];
    bpu_cnt_e  cnt_next;
    bpu_pred_t pred_q;
    bpu_pred_t pred_d;

    logic unused_bits;

    assign q_bht_idx = fetch_pc[BHT_IDX_W+1:2];
    assign q_btb_idx = fetch_pc[BTB_IDX_W+1:2];
    assign q_tag     = fetch_pc[31:BTB_IDX_W+2];
    assign u_bht_idx = update_info.pc_dispatch[BHT_IDX_W+1:2];
    assign u_btb_idx = update_info.pc_dispatch[BTB_IDX_W+1:2];
    assign u_tag     = update_info.pc_dispatch[31:BTB_IDX_W+2];

    // Only taken branches train the BTB; a not-taken target carries no information.
    assign btb_wr_en = update_info.update_en && update_info.taken_or_not_actual && !rst;

    btb_ram #(
        .DEPTH (BTB_DEPTH),
        .IDX_W (BTB_IDX_W),
        .TAG_W (BTB_TAG_W)
    ) u_btb_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (q_btb_idx),
        .rd_valid  (btb_rd_valid),
        .rd_tag    (btb_rd_tag),
        .rd_target (btb_rd_target),
        .wr_en     (btb_wr_en),
        .wr_idx    (u_btb_idx),
        .wr_tag    (u_tag),
        .wr_target (update_info.branch_actual_addr)
    );

    assign btb_hit = btb_rd_valid && (btb_rd_tag == q_tag);
    assign q_taken = btb_hit &&
                     ((cnt_q[q_bht_idx] == BPU_CNT_WT) || (cnt_q[q_bht_idx] == BPU_CNT_ST));

    always_comb begin
        cnt_next = cnt_q[u_bht_idx];
        unique case (cnt_q[u_bht_idx])
            BPU_CNT_SNT: cnt_next = update_info.taken_or_not_actual ? BPU_CNT_WNT : BPU_CNT_SNT;
            BPU_CNT_WNT: cnt_next = update_info.taken_or_not_actual ? BPU_CNT_WT  : BPU_CNT_SNT;
            BPU_CNT_WT:  cnt_next = update_info.taken_or_not_actual ? BPU_CNT_ST  : BPU_CNT_WNT;
            BPU_CNT_ST:  cnt_next = update_info.taken_or_not_actual ? BPU_CNT_ST  : BPU_CNT_WT;
        endcase

        cnt_d = cnt_q;
        if (update_info.update_en) begin
            cnt_d[u_bht_idx] = cnt_next;
        end
    end

    // A stall freezes the outputs; an idle fetch slot clears them.
    always_comb begin
        pred_d = pred_q;
        if (!fetch_stall) begin
            if (fetch_valid) begin
                pred_d.valid  = 1'b1;
                pred_d.taken  = q_taken;
                pred_d.target = q_taken ? btb_rd_target : fetch_pc + 32'd4;
                pred_d.pc     = fetch_pc;
            end else begin
                pred_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= BPU_CNT_WNT;
            end
        end else begin
            pred_q <= pred_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pred_valid          = pred_q.valid;
    assign pre_is_branch_taken = pred_q.taken;
    assign pre_branch_addr     = pred_q.target;
    assign pred_pc             = pred_q.pc;

    assign unused_bits = ^{fetch_pc[1:0], update_info.pc_dispatch[1:0], update_info.branch_flush};

endmodule
